// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: write-side controller for the camera frame buffer.
// Samples an 8-bit camera bus (RGB565, two bytes per pixel) between VSYNC/HREF framing, packs
// each pixel to RGB332 and writes it row-major at row*CAM_SCREEN_X + col. At frame end a border
// value is written to address CAM_SCREEN_X*CAM_SCREEN_Y.
//
// Ports:
//   clk             camera pixel clock; all logic on the rising edge
//   rst             synchronous active-high reset
//   capture_en      1 = capture frames continuously, 0 = stop after the current frame
//   cam_vsync       camera VSYNC, high between frames
//   cam_href        camera HREF, high while line bytes are valid
//   cam_data        camera byte bus
//   DP_RAM_addr_in  RAM write address (registered)
//   DP_RAM_data_in  RAM write data, RGB332 (registered)
//   DP_RAM_regW     RAM write enable, one cycle per write (registered)
//   frame_done      one-cycle pulse after the border write
//   busy            high whenever the controller is not idle
//
// Build option: define CAM_TEST_PATTERN_EN to replace camera data with a col/row test pattern.

module cam_capture_ctrl #(
   parameter int unsigned   CAM_SCREEN_X = 160,
   parameter int unsigned   CAM_SCREEN_Y = 120,
   parameter int unsigned   AW           = 15,
   parameter int unsigned   DW           = 8,
   parameter logic [DW-1:0] BORDER_COLOR = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          capture_en,
   input  logic          cam_vsync,
   input  logic          cam_href,
   input  logic [7:0]    cam_data,
   output logic [AW-1:0] DP_RAM_addr_in,
   output logic [DW-1:0] DP_RAM_data_in,
   output logic          DP_RAM_regW,
   output logic          frame_done,
   output logic          busy
);

   localparam int unsigned CW = $clog2(CAM_SCREEN_X + 1);
   localparam int unsigned RW = $clog2(CAM_SCREEN_Y + 1);
   localparam logic [CW-1:0] ColMax     = CW'(CAM_SCREEN_X);
   localparam logic [RW-1:0] RowMax     = RW'(CAM_SCREEN_Y);
   localparam logic [AW-1:0] LineStep   = AW'(CAM_SCREEN_X);
   localparam logic [AW-1:0] BorderAddr = AW'(CAM_SCREEN_X * CAM_SCREEN_Y);

   typedef enum logic [2:0] {StIdle, StWaitFrame, StCapture, StBorder, StDone} state_e;

   state_e        state_q, state_d;
   logic          vsync_q, href_q;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [AW-1:0] base_q, base_d;
   logic          phase_q, phase_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;
   logic          we_q, we_d;
   logic [7:0]    pixel;

   logic vsync_fall, vsync_rise, href_fall;
   assign vsync_fall = vsync_q & ~cam_vsync;
   assign vsync_rise = ~vsync_q & cam_vsync;
   assign href_fall  = href_q & ~cam_href;

`ifdef CAM_TEST_PATTERN_EN
   logic [4:0] col5;
   logic [2:0] row3;
   assign col5  = 5'(col_q);
   assign row3  = 3'(row_q);
   assign pixel = {col5[2:0], row3, col5[4:3]};
`else
   // Only the bits of the first byte that survive RGB332 packing are kept: R[7:5], G-high[2:0].
   logic [5:0] b1_q, b1_d;
   assign pixel = {b1_q[5:3], b1_q[2:0], cam_data[4:3]};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         vsync_q <= 1'b0;
         href_q  <= 1'b0;
         col_q   <= '0;
         row_q   <= '0;
         base_q  <= '0;
         phase_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
`ifndef CAM_TEST_PATTERN_EN
         b1_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         vsync_q <= cam_vsync;
         href_q  <= cam_href;
         col_q   <= col_d;
         row_q   <= row_d;
         base_q  <= base_d;
         phase_q <= phase_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         we_q    <= we_d;
`ifndef CAM_TEST_PATTERN_EN
         b1_q    <= b1_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      base_d  = base_q;
      phase_d = phase_q;
      addr_d  = addr_q;
      data_d  = data_q;
      we_d    = 1'b0;
`ifndef CAM_TEST_PATTERN_EN
      b1_d    = b1_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (capture_en) state_d = StWaitFrame;
         end
         StWaitFrame: begin
            if (vsync_fall) begin
               state_d = StCapture;
               col_d   = '0;
               row_d   = '0;
               base_d  = '0;
               phase_d = 1'b0;
            end
         end
         StCapture: begin
            if (vsync_rise) begin
               // Frame end wins over any partial pixel; border write issued with registered outputs.
               state_d = StBorder;
               phase_d = 1'b0;
               we_d    = 1'b1;
               addr_d  = BorderAddr;
               data_d  = BORDER_COLOR;
            end else if (href_fall) begin
               phase_d = 1'b0;
               col_d   = '0;
               if (row_q < RowMax) begin
                  row_d  = row_q + 1'b1;
                  base_d = base_q + LineStep;
               end
            end else if (cam_href) begin
               if (!phase_q) begin
                  phase_d = 1'b1;
`ifndef CAM_TEST_PATTERN_EN
                  b1_d    = {cam_data[7:5], cam_data[2:0]};
`endif
               end else begin
                  phase_d = 1'b0;
                  // Out-of-window pixels are dropped; col saturates at ColMax.
                  if ((col_q < ColMax) && (row_q < RowMax)) begin
                     we_d   = 1'b1;
                     addr_d = base_q + AW'(col_q);
                     data_d = DW'(pixel);
                     col_d  = col_q + 1'b1;
                  end
               end
            end
         end
         StBorder: begin
            state_d = StDone;
         end
         StDone: begin
            state_d = capture_en ? StWaitFrame : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign DP_RAM_addr_in = addr_q;
   assign DP_RAM_data_in = data_q;
   assign DP_RAM_regW    = we_q;
   assign frame_done     = (state_q == StDone);
   assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_cam_capture_ctrl.sv
module tb_cam_capture_ctrl;

   localparam int unsigned X  = 8;
   localparam int unsigned Y  = 4;
   localparam int unsigned AW = 6;
   localparam int unsigned DW = 8;
   localparam logic [7:0]  BC = 8'h5A;

`ifdef CAM_TEST_PATTERN_EN
   localparam logic [7:0] E_P0 = 8'h00, E_P1 = 8'h20, E_P8 = 8'h04, E_P9 = 8'h24;
   localparam logic [7:0] E_P16 = 8'h08, E_P21 = 8'hA8, E_P31 = 8'hEC, E_T5 = 8'h00;
`else
   localparam logic [7:0] E_P0 = 8'hA3, E_P1 = 8'hE7, E_P8 = 8'h32, E_P9 = 8'h79;
   localparam logic [7:0] E_P16 = 8'hC1, E_P21 = 8'hB7, E_P31 = 8'hFC, E_T5 = 8'h0A;
`endif

   logic          clk = 1'b0;
   logic          rst, capture_en, cam_vsync, cam_href;
   logic [7:0]    cam_data;
   logic [AW-1:0] DP_RAM_addr_in;
   logic [DW-1:0] DP_RAM_data_in;
   logic          DP_RAM_regW, frame_done, busy;

   cam_capture_ctrl #(
      .CAM_SCREEN_X(X), .CAM_SCREEN_Y(Y), .AW(AW), .DW(DW), .BORDER_COLOR(BC)
   ) dut (
      .clk(clk), .rst(rst), .capture_en(capture_en), .cam_vsync(cam_vsync),
      .cam_href(cam_href), .cam_data(cam_data), .DP_RAM_addr_in(DP_RAM_addr_in),
      .DP_RAM_data_in(DP_RAM_data_in), .DP_RAM_regW(DP_RAM_regW),
      .frame_done(frame_done), .busy(busy)
   );

   always #5 clk = ~clk;

   // RAM model fed by the write port.
   logic [7:0] mem [64];
   int         wr_cnt [64];
   int         wcount = 0;
   int         last_addr = -1;

   always @(negedge clk) begin
      if (DP_RAM_regW === 1'b1) begin
         mem[DP_RAM_addr_in]    = DP_RAM_data_in;
         wr_cnt[DP_RAM_addr_in] = wr_cnt[DP_RAM_addr_in] + 1;
         wcount                 = wcount + 1;
         last_addr              = int'(DP_RAM_addr_in);
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      cam_href = 1'b1;
      cam_data = b;
      tick();
   endtask

   task automatic end_line();
      cam_href = 1'b0;
      tick();
      tick();
   endtask

   task automatic vsync_fall();
      cam_vsync = 1'b1;
      tick();
      tick();
      cam_vsync = 1'b0;
      tick();
   endtask

   task automatic pixel_bytes(input logic [7:0] a, input logic [7:0] b);
`ifdef CAM_TEST_PATTERN_EN
      send_byte(8'($urandom));
      send_byte(8'($urandom));
`else
      send_byte(a);
      send_byte(b);
`endif
   endtask

   int snap, snap8, snap32;

   initial begin
      rst = 1'b1; capture_en = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
      tick();
      tick();
      check("rst_regW", DP_RAM_regW, 1'b0);
      check("rst_addr", DP_RAM_addr_in, '0);
      check("rst_data", DP_RAM_data_in, '0);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_busy", busy, 1'b0);
      rst = 1'b0;
      tick();
      check("idle_busy", busy, 1'b0);
      capture_en = 1'b1;
      tick();
      check("wait_busy", busy, 1'b1);

      // T1: href in WAIT_FRAME ignored, then 2 lines x 2 pixels.
      snap = wcount;
      send_byte(8'h11);
      send_byte(8'h22);
      end_line();
      check("wait_href_ignored", wcount - snap, 0);
      vsync_fall();
      snap = wcount;
      pixel_bytes(8'hA0, 8'h1F);
      check("t1_lat_regW", DP_RAM_regW, 1'b1);
      check("t1_lat_addr", DP_RAM_addr_in, 0);
      pixel_bytes(8'hE1, 8'h18);
      end_line();
      pixel_bytes(8'h3C, 8'hF0);
      pixel_bytes(8'h7E, 8'h08);
      end_line();
      check("t1_writes", wcount - snap, 4);
      check("t1_p0", mem[0], E_P0);
      check("t1_p1", mem[1], E_P1);
      check("t1_row1_start", wr_cnt[8], 1);
      check("t1_p8", mem[8], E_P8);
      check("t1_p9", mem[9], E_P9);
      cam_vsync = 1'b1;
      tick();
      check("t1_border_regW", DP_RAM_regW, 1'b1);
      check("t1_border_addr", DP_RAM_addr_in, X * Y);
      tick();
      check("t1_frame_done", frame_done, 1'b1);
      tick();
      check("t1_frame_done_off", frame_done, 1'b0);
      check("t1_rearm_busy", busy, 1'b1);

      // T2: over-long line, writes clamp at X.
      vsync_fall();
      snap = wcount;
      snap8 = wr_cnt[8];
      for (int i = 0; i < 2 * (X + 5); i++) send_byte(8'(i));
      end_line();
      check("t2_writes", wcount - snap, X);
      check("t2_last_addr", last_addr, X - 1);
      check("t2_no_addr_x", wr_cnt[8] - snap8, 0);

      // T4: odd byte count, dangling byte dropped.
      snap = wcount;
      for (int i = 0; i < 2 * X + 1; i++) send_byte(8'(8'h40 + i));
      end_line();
      check("t4_writes", wcount - snap, X);
      check("t4_last_addr", last_addr, 2 * X - 1);
      pixel_bytes(8'hC0, 8'h08);
      check("t4_next_addr", last_addr, 2 * X);
      check("t4_next_phase0", mem[2 * X], E_P16);
      for (int i = 1; i < X; i++) pixel_bytes(8'hA5, 8'h5A);
      end_line();
      check("t6_pixel_c5_r2", mem[2 * X + 5], E_P21);

      // T3: row 3 full, rows 4..6 clamped, then border.
      for (int i = 0; i < X; i++) pixel_bytes(8'hFF, 8'h00);
      end_line();
      check("t3_last_pixel", last_addr, X * Y - 1);
      check("t3_p31", mem[X * Y - 1], E_P31);
      snap = wcount;
      snap32 = wr_cnt[X * Y];
      for (int l = 0; l < 3; l++) begin
         for (int i = 0; i < 2 * X; i++) send_byte(8'h77);
         end_line();
      end
      check("t3_clamp_rows", wcount - snap, 0);
      check("t3_no_early_border", wr_cnt[X * Y] - snap32, 0);
      capture_en = 1'b0;
      cam_vsync = 1'b1;
      tick();
      check("t3_border_regW", DP_RAM_regW, 1'b1);
      check("t3_border_addr", DP_RAM_addr_in, X * Y);
      check("t3_border_data", DP_RAM_data_in, BC);
      check("t3_border_busy", busy, 1'b1);
      tick();
      check("t3_frame_done", frame_done, 1'b1);
      check("t3_done_regW", DP_RAM_regW, 1'b0);
      tick();
      check("t3_frame_done_off", frame_done, 1'b0);
      check("t3_idle_busy", busy, 1'b0);

      // T5: reset mid-line, then re-arm.
      capture_en = 1'b1;
      tick();
      vsync_fall();
      send_byte(8'hA0);
      rst = 1'b1;
      cam_href = 1'b1;
      cam_data = 8'h1F;
      tick();
      check("t5_rst_regW", DP_RAM_regW, 1'b0);
      check("t5_rst_busy", busy, 1'b0);
      rst = 1'b0;
      capture_en = 1'b0;
      snap = wcount;
      for (int i = 0; i < 4; i++) send_byte(8'h12);
      cam_href = 1'b0;
      vsync_fall();
      for (int i = 0; i < 4; i++) send_byte(8'h12);
      end_line();
      check("t5_idle_no_write", wcount - snap, 0);
      check("t5_idle_busy", busy, 1'b0);
      capture_en = 1'b1;
      tick();
      check("t5_armed_busy", busy, 1'b1);
      for (int i = 0; i < 4; i++) send_byte(8'h12);
      end_line();
      check("t5_no_write_wo_fall", wcount - snap, 0);
      vsync_fall();
      pixel_bytes(8'h12, 8'h34);
      check("t5_write_after_fall", wcount - snap, 1);
      check("t5_addr", last_addr, 0);
      check("t5_data", mem[0], E_T5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
